// File: rtl/rv_pkg.sv
// rv_pkg: shared sizes and types for the fetch window
package rv_pkg;
    localparam int BUF_DEPTH  = 8;
    localparam int WIN_HALVES = 4;

    typedef logic [15:0] half_t;

    typedef enum logic {
        STREAM = 1'b0,
        FILL   = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/rv_halfword_rotate.sv
// rv_halfword_rotate: picks WIN_HALVES consecutive halfwords from a circular buffer starting at shift_i
module rv_halfword_rotate
    import rv_pkg::*;
(
    input  half_t [BUF_DEPTH-1:0]  entries_i,
    input  logic  [2:0]            shift_i,
    output half_t [WIN_HALVES-1:0] halves_o
);
    for (genvar i = 0; i < WIN_HALVES; i++) begin : g_rot
        logic [2:0] idx;
        assign idx         = shift_i + 3'(i);
        assign halves_o[i] = entries_i[idx];
    end
endmodule

// File: rtl/rv_fetch_window.sv
// rv_fetch_window: halfword fetch buffer presenting a 4-halfword decode window at the head
module rv_fetch_window
    import rv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [63:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic [63:0] window,
    output logic [2:0]  window_halves,
    output logic [63:0] window_pc,
    input  logic        consume_valid,
    input  logic [1:0]  consume_len_half_minus_one,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);
    half_t [BUF_DEPTH-1:0] hw_q;
    logic [2:0]   head_q, head_d, tail_q, tail_d;
    logic [3:0]   occ_q, occ_d;
    logic [63:0]  pc_q, pc_d, addr_q, addr_d;
    fetch_state_e state_q, state_d;
    logic         skip_low, accept, consume_ok;
    logic [3:0]   n, add_n, sub_n;

    assign fetch_ready   = occ_q <= 4'd6;
    assign window_halves = occ_q[3] || occ_q[2] ? 3'd4 : occ_q[2:0];
    assign window_pc     = pc_q;
    assign fetch_addr    = addr_q;
    assign accept        = fetch_valid && fetch_ready && !redirect_valid;
    assign n             = {2'b00, consume_len_half_minus_one} + 4'd1;
    assign consume_ok    = consume_valid && !redirect_valid && n <= {1'b0, window_halves};
    assign add_n         = accept ? (skip_low ? 4'd1 : 4'd2) : 4'd0;
    assign sub_n         = consume_ok ? n : 4'd0;

    rv_halfword_rotate u_rotate (
        .entries_i (hw_q),
        .shift_i   (head_q),
        .halves_o  (window)
    );

    // FILL/STREAM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= STREAM;
        else       state_q <= state_d;
    end

    // A redirect picks the state from its halfword alignment; the first accepted word ends FILL
    always_comb begin
        state_d = redirect_valid ? (redirect_pc[1] ? FILL : STREAM) : accept ? STREAM : state_q;
    end

    // FILL means the upper halfword of the next word is the first one wanted
    always_comb begin
        skip_low = state_q == FILL;
    end

    // Next pointers, occupancy and PCs; a redirect flushes and drops same-cycle fetch/consume
    always_comb begin
        head_d = redirect_valid ? 3'd0 : head_q + sub_n[2:0];
        tail_d = redirect_valid ? 3'd0 : tail_q + add_n[2:0];
        occ_d  = redirect_valid ? 4'd0 : occ_q + add_n - sub_n;
        pc_d   = redirect_valid ? redirect_pc & ~64'h1 : pc_q + {59'd0, sub_n, 1'b0};
        addr_d = redirect_valid ? redirect_pc & ~64'h3 : addr_q + (accept ? 64'd4 : 64'd0);
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            pc_q   <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            pc_q   <= pc_d;
            addr_q <= addr_d;
        end
    end

    // Halfword storage is never reset; only occupancy says what is valid
    always_ff @(posedge clock) begin
        if (accept && skip_low) begin
            hw_q[tail_q] <= fetch_data[31:16];
        end else if (accept) begin
            hw_q[tail_q]        <= fetch_data[15:0];
            hw_q[tail_q + 3'd1] <= fetch_data[31:16];
        end
    end

    // Consuming more halfwords than the window holds is a decoder bug; the consume is ignored
    always_ff @(posedge clock) begin
        if (!reset && consume_valid && !redirect_valid)
            assert (n <= {1'b0, window_halves})
            else $warning("rv_fetch_window: consume of %0d halfwords with only %0d valid", n, window_halves);
    end
endmodule

// File: tb/tb_rv_fetch_window.sv
// tb_rv_fetch_window: directed vector table plus randomized run against a halfword-queue model
module tb_rv_fetch_window;
    logic        clock = 0;
    logic        reset;
    logic [63:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [63:0] window;
    logic [2:0]  window_halves;
    logic [63:0] window_pc;
    logic        consume_valid;
    logic [1:0]  consume_len_half_minus_one;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    rv_fetch_window #(.RESET_PC(64'h0)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .fetch_addr                 (fetch_addr),
        .fetch_valid                (fetch_valid),
        .fetch_data                 (fetch_data),
        .fetch_ready                (fetch_ready),
        .window                     (window),
        .window_halves              (window_halves),
        .window_pc                  (window_pc),
        .consume_valid              (consume_valid),
        .consume_len_half_minus_one (consume_len_half_minus_one),
        .redirect_valid             (redirect_valid),
        .redirect_pc                (redirect_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        fv;
        logic [31:0] data;
        logic        cv;
        logic [1:0]  len;
        logic        rv;
        logic [63:0] rpc;
        logic [2:0]  e_halves;
        logic [63:0] e_pc;
        logic [63:0] e_addr;
        logic        e_ready;
        logic [31:0] e_win;
        logic [31:0] e_mask;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fv, input logic [31:0] d, input logic cv,
                         input logic [1:0] len, input logic rv, input logic [63:0] rpc);
        reset = rst;
        fetch_valid = fv;
        fetch_data = d;
        consume_valid = cv;
        consume_len_half_minus_one = len;
        redirect_valid = rv;
        redirect_pc = rpc;
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(logic fv, logic [31:0] d, logic cv, logic [1:0] len, logic rv, logic [63:0] rpc,
                                logic [2:0] eh, logic [63:0] epc, logic [63:0] ea, logic er,
                                logic [31:0] ew, logic [31:0] em);
        vec_t v;
        v.fv = fv; v.data = d; v.cv = cv; v.len = len; v.rv = rv; v.rpc = rpc;
        v.e_halves = eh; v.e_pc = epc; v.e_addr = ea; v.e_ready = er; v.e_win = ew; v.e_mask = em;
        return v;
    endfunction

    logic [15:0] q[$];
    logic [63:0] mpc, maddr;
    logic        mskip;

    task automatic check_model();
        int h;
        h = q.size() > 4 ? 4 : q.size();
        chk("rnd_ready", fetch_ready, q.size() <= 6);
        chk("rnd_halves", window_halves, h);
        chk("rnd_pc", window_pc, mpc);
        chk("rnd_addr", fetch_addr, maddr);
        for (int i = 0; i < h; i++) chk("rnd_win", window[16*i +: 16], q[i]);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'hDEADBEEF, 1, 3, 1, 64'h55);
        chk("rst_halves", window_halves, 0);
        chk("rst_pc", window_pc, 0);
        chk("rst_addr", fetch_addr, 0);
        chk("rst_ready", fetch_ready, 1);

        vecs.push_back(mk(1, 32'h00A00513, 0, 0, 0, 0, 2, 64'h0, 64'h4, 1, 32'h00A00513, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 32'h11112222, 0, 0, 0, 0, 4, 64'h0, 64'h8, 1, 32'h00A00513, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 32'h33334444, 0, 0, 0, 0, 4, 64'h0, 64'hC, 1, 32'h00A00513, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 32'h55556666, 0, 0, 0, 0, 4, 64'h0, 64'h10, 0, 32'h00A00513, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 32'h77778888, 0, 0, 0, 0, 4, 64'h0, 64'h10, 0, 32'h00A00513, 32'hFFFFFFFF));
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, 4, 64'h8, 64'h10, 1, 32'h33334444, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 32'h9999AAAA, 1, 3, 0, 0, 2, 64'h10, 64'h14, 1, 32'h9999AAAA, 32'hFFFFFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h102, 0, 64'h102, 64'h100, 1, 0, 0));
        vecs.push_back(mk(1, 32'hBBBBAAAA, 0, 0, 0, 0, 1, 64'h102, 64'h104, 1, 32'h0000BBBB, 32'h0000FFFF));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 64'h102, 64'h104, 1, 32'h0000BBBB, 32'h0000FFFF));
        vecs.push_back(mk(1, 32'hCCCCDDDD, 1, 0, 1, 64'h200, 0, 64'h200, 64'h200, 1, 0, 0));
        vecs.push_back(mk(1, 32'h12345678, 0, 0, 0, 0, 2, 64'h200, 64'h204, 1, 32'h12345678, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 32'h00000000, 1, 0, 0, 0, 3, 64'h202, 64'h208, 1, 32'h00001234, 32'hFFFFFFFF));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFC, 1, 0, 0));
        vecs.push_back(mk(1, 32'hEEEEFFFF, 0, 0, 0, 0, 1, 64'hFFFFFFFFFFFFFFFE, 64'h0, 1, 32'h0000EEEE, 32'h0000FFFF));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 64'h0, 64'h0, 1, 0, 0));

        foreach (vecs[k]) begin
            drive(0, vecs[k].fv, vecs[k].data, vecs[k].cv, vecs[k].len, vecs[k].rv, vecs[k].rpc);
            chk($sformatf("vec%0d_halves", k), window_halves, vecs[k].e_halves);
            chk($sformatf("vec%0d_pc", k), window_pc, vecs[k].e_pc);
            chk($sformatf("vec%0d_addr", k), fetch_addr, vecs[k].e_addr);
            chk($sformatf("vec%0d_ready", k), fetch_ready, vecs[k].e_ready);
            if (vecs[k].e_mask != 0)
                chk($sformatf("vec%0d_win", k), window[31:0] & vecs[k].e_mask, vecs[k].e_win);
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        q.delete();
        mpc = 0;
        maddr = 0;
        mskip = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        rst, fv, cv, rv, rdy;
            logic [1:0]  len;
            logic [31:0] d;
            logic [63:0] rpc;
            int          n, h;
            check_model();
            rst = $urandom_range(0, 99) == 0;
            fv  = $urandom_range(0, 3) != 0;
            cv  = $urandom_range(0, 1) == 1;
            len = 2'($urandom_range(0, 3));
            rv  = $urandom_range(0, 19) == 0;
            d   = $urandom;
            rpc = $urandom_range(0, 3) == 0 ? 64'hFFFFFFFFFFFFFFF0 | 64'($urandom_range(0, 15))
                                            : {32'($urandom), 32'($urandom)};
            rdy = q.size() <= 6;
            h   = q.size() > 4 ? 4 : q.size();
            n   = int'(len) + 1;
            if (rst) begin
                q.delete();
                mpc = 0;
                maddr = 0;
                mskip = 0;
            end else if (rv) begin
                q.delete();
                mpc = {rpc[63:1], 1'b0};
                maddr = {rpc[63:2], 2'b00};
                mskip = rpc[1];
            end else begin
                if (cv && n <= h) begin
                    for (int j = 0; j < n; j++) void'(q.pop_front());
                    mpc = mpc + 64'(2 * n);
                end
                if (fv && rdy) begin
                    if (!mskip) q.push_back(d[15:0]);
                    q.push_back(d[31:16]);
                    mskip = 0;
                    maddr = maddr + 64'd4;
                end
            end
            drive(rst, fv, d, cv, len, rv, rpc);
        end
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_fetch_window.md
RV_FETCH_WINDOW -- requirements
Module: rv_fetch_window

Interface
REQ-001 The parameter list SHALL be: RESET_PC, 64'h0, architectural PC and fetch address after reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 The ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- fetch_addr  out  64  4-byte-aligned address of the word requested this cycle
- fetch_valid  in  1  fetch_data holds the word at fetch_addr
- fetch_data  in  32  little-endian instruction word
- fetch_ready  out  1  block accepts fetch_data this cycle
- window  out  64  four halfwords from head; halfword i at bits [16i+:16]
- window_halves  out  3  valid halfwords in window, 0..4
- window_pc  out  64  PC of window halfword 0
- consume_valid  in  1  decoder/fusion retires an instruction group this cycle
- consume_len_half_minus_one  in  2  group length in halfwords minus one (fusion length output)
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  64  new PC; bit 0 ignored

Function
REQ-004 Storage SHALL be an 8-entry halfword circular buffer with a 3-bit head, a 3-bit tail and a 4-bit occupancy count of 0..8.
REQ-005 fetch_ready SHALL be 1 iff occupancy <= 6 at the start of the cycle; it SHALL NOT depend combinationally on consume or redirect.
REQ-006 An accepted word (fetch_valid && fetch_ready && !redirect_valid) SHALL:
- write data[15:0] then data[31:16] at tail, then tail += 2, occupancy += 2, fetch_addr += 4;
- exception: when skip_low = 1, write only data[31:16], then tail += 1, occupancy += 1, clear skip_low.
REQ-007 window halfword i SHALL equal buf[head+i mod 8] for i < window_halves; halfwords at or above window_halves are don't-care.
REQ-008 window_halves SHALL equal min(occupancy, 4).
REQ-009 A legal consume SHALL advance head by n = consume_len_half_minus_one+1, decrement occupancy by n, and advance window_pc by 2n (64-bit wrap).
REQ-010 A consume with n > window_halves SHALL be illegal: state is unchanged, and an assertion fires in simulation.
REQ-011 A simultaneous accepted fetch and legal consume SHALL net the occupancy change within one cycle; the result never exceeds 8, guaranteed by REQ-005.
REQ-012 A redirect SHALL take priority over fetch and consume in the same cycle, and on the next edge SHALL set:
- occupancy = 0, head = tail = 0;
- window_pc = {redirect_pc[63:1],1'b0};
- fetch_addr = {redirect_pc[63:2],2'b00};
- skip_low = redirect_pc[1].
The fetch word and the consume in that cycle are dropped.
REQ-013 The block SHALL have two states: FILL (skip_low = 1) and STREAM (skip_low = 0). Transitions:
- FILL -> STREAM on the first accepted word;
- any state -> FILL on a redirect with redirect_pc[1] = 1;
- any state -> STREAM on a redirect with redirect_pc[1] = 0.
REQ-014 Pointer and PC arithmetic SHALL wrap modulo width; there is no error on wrap.
REQ-015 All outputs SHALL be functions of registered state only, giving 1-cycle latency from fetch accept to window visibility.

Reset
REQ-016 While reset is asserted:
- occupancy = 0, head = tail = 0, skip_low = 0, state = STREAM;
- window_pc = fetch_addr = RESET_PC;
- window_halves = 0, fetch_ready = 1.
REQ-017 Reset SHALL override a redirect, fetch or consume in the same cycle.
REQ-018 Buffer data SHALL NOT be reset.

Structure
REQ-019 Buffer depth (8), window width (4) and the halfword type SHALL live in the shared package rv_pkg.
REQ-020 The head-rotation read mux SHALL be the single sub-module rv_halfword_rotate (8 entries in, 4 halfwords out, 3-bit shift).

Verification
REQ-021 Reset, then feed word 32'h00A00513 at addr 0 -> next cycle window_halves = 2, window[31:0] = 32'h00A00513, window_pc = 0.
REQ-022 Feed 4 words with no consume -> fetch_ready drops to 0 after the 4th accept (occupancy 8) and fetch_addr holds at 16.
REQ-023 Occupancy 4, consume len 3 (fused 8-byte pair) with a simultaneous fetch -> occupancy 2, window_pc += 8.
REQ-024 Redirect to 64'h102 -> fetch_addr = 64'h100; the next word 32'hBBBBAAAA yields window_halves = 1, window[15:0] = 16'hBBBB, window_pc = 64'h102.
REQ-025 Occupancy 1, consume len 1 -> assertion fires; occupancy stays 1 and window_pc is unchanged.
REQ-026 Redirect, consume and fetch all in one cycle -> only the redirect takes effect and occupancy = 0 next cycle.
